// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder: field limits,
// exponent bias and the unpacked operand record.
package fp_pkg;

    localparam int EXP_W_MAX = 8;
    localparam int MAN_W_MAX = 23;
    localparam int GUARD_W   = 3;
    // Signed working exponent, wide enough for carry-out and deep cancellation.
    localparam int XEXP_W    = 10;

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_MAX-1:0] exp;
        logic [MAN_W_MAX:0]   man;
    } fp_op_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports the full width.
module fp_lzc #(
    parameter int W = 8
) (
    input  logic [W-1:0]             value,
    output logic [$clog2(W+1)-1:0]   zeros
);

    localparam int CW = $clog2(W + 1);

    // Scanning upward lets the highest set bit overwrite any lower hit.
    always_comb begin
        zeros = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                zeros = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Five-stage floating-point adder/subtractor with a single global stall enable.
// Define FP_ADD_STICKY_EN to fold alignment shift-out bits into the lowest guard bit.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [EXP_W+MAN_W:0]     data_1_i,
    input  logic [EXP_W+MAN_W:0]     data_2_i,
    input  logic                     sub_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [EXP_W+MAN_W:0]     data_sum_o
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int GW  = MAN_W + 1 + GUARD_W;
    localparam int SW  = GW + 1;
    localparam int LZW = $clog2(SW + 1);
    localparam logic [XEXP_W-1:0] EXP_TOP = XEXP_W'((1 << EXP_W) - 1);

    logic en;
    assign en      = ready_i | ~valid_o;
    assign ready_o = en | rst_i;

    function automatic fp_op_t unpack(input logic [W-1:0] d, input logic flip);
        fp_op_t op;
        op = '0;
        if (d[W-2 -: EXP_W] != '0) begin
            op.sign              = d[W-1] ^ flip;
            op.exp[EXP_W-1:0]    = d[W-2 -: EXP_W];
            op.man[MAN_W:0]      = {1'b1, d[MAN_W-1:0]};
        end
        return op;
    endfunction

    // Stage 1: unpack and order the operands so the larger magnitude leads.
    fp_op_t           op_a, op_b;
    logic             a_big;
    logic [EXP_W-1:0] exp_diff;

    always_comb begin
        op_a     = unpack(data_1_i, 1'b0);
        op_b     = unpack(data_2_i, sub_i);
        a_big    = {op_a.exp, op_a.man} >= {op_b.exp, op_b.man};
        exp_diff = a_big ? (op_a.exp[EXP_W-1:0] - op_b.exp[EXP_W-1:0])
                         : (op_b.exp[EXP_W-1:0] - op_a.exp[EXP_W-1:0]);
    end

    logic             s1_valid, s1_sign, s1_sub;
    logic [EXP_W-1:0] s1_exp, s1_diff;
    logic [MAN_W:0]   s1_man_big, s1_man_small;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_sub       <= 1'b0;
            s1_exp       <= '0;
            s1_diff      <= '0;
            s1_man_big   <= '0;
            s1_man_small <= '0;
        end else if (en) begin
            s1_valid     <= valid_i;
            s1_sign      <= a_big ? op_a.sign : op_b.sign;
            s1_sub       <= op_a.sign ^ op_b.sign;
            s1_exp       <= a_big ? op_a.exp[EXP_W-1:0] : op_b.exp[EXP_W-1:0];
            s1_diff      <= exp_diff;
            s1_man_big   <= a_big ? op_a.man[MAN_W:0] : op_b.man[MAN_W:0];
            s1_man_small <= a_big ? op_b.man[MAN_W:0] : op_a.man[MAN_W:0];
        end
    end

    // Stage 2: align the smaller significand; the lower half catches shifted-out bits.
    logic [2*GW-1:0] shifted;
    logic            sticky;
    logic [GW-1:0]   aligned;

    assign shifted = {s1_man_small, {GUARD_W{1'b0}}, {GW{1'b0}}} >> s1_diff;

`ifdef FP_ADD_STICKY_EN
    assign sticky = |shifted[GW-1:0];
`else
    logic unused_lost;
    assign unused_lost = |shifted[GW-1:0];
    assign sticky      = 1'b0;
`endif

    assign aligned = (32'(s1_diff) >= 32'(GW)) ? '0
                   : (shifted[2*GW-1:GW] | GW'(sticky));

    logic             s2_valid, s2_sign, s2_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [GW-1:0]    s2_big, s2_small;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_sub   <= 1'b0;
            s2_exp   <= '0;
            s2_big   <= '0;
            s2_small <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_sub   <= s1_sub;
            s2_exp   <= s1_exp;
            s2_big   <= {s1_man_big, {GUARD_W{1'b0}}};
            s2_small <= aligned;
        end
    end

    // Stage 3: magnitude add or subtract; ordering guarantees a non-negative difference.
    logic             s3_valid, s3_sign;
    logic [EXP_W-1:0] s3_exp;
    logic [SW-1:0]    s3_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s3_valid <= 1'b0;
            s3_sign  <= 1'b0;
            s3_exp   <= '0;
            s3_sum   <= '0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_sign  <= s2_sign;
            s3_exp   <= s2_exp;
            s3_sum   <= s2_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                               : ({1'b0, s2_big} + {1'b0, s2_small});
        end
    end

    // Stage 4: normalise so the leading one sits in the carry position.
    logic [LZW-1:0]    lz;
    logic [SW-1:0]     norm;
    logic [XEXP_W-1:0] norm_exp;
    logic              unused_norm;

    fp_lzc #(.W(SW)) u_lzc (
        .value (s3_sum),
        .zeros (lz)
    );

    assign norm        = s3_sum << lz;
    assign norm_exp    = XEXP_W'(s3_exp) + XEXP_W'(1) - XEXP_W'(lz);
    assign unused_norm = ^norm[GUARD_W-1:0];

    logic              s4_valid, s4_sign, s4_zero;
    logic [XEXP_W-1:0] s4_exp;
    logic [MAN_W+1:0]  s4_man;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s4_valid <= 1'b0;
            s4_sign  <= 1'b0;
            s4_zero  <= 1'b0;
            s4_exp   <= '0;
            s4_man   <= '0;
        end else if (en) begin
            s4_valid <= s3_valid;
            s4_sign  <= s3_sign;
            s4_zero  <= (s3_sum == '0);
            s4_exp   <= norm_exp;
            s4_man   <= norm[SW-1:GUARD_W];
        end
    end

    // Stage 5: round half away from zero, then saturate or flush out-of-range exponents.
    logic [MAN_W+1:0]  rnd;
    logic [XEXP_W-1:0] rexp;
    logic [MAN_W-1:0]  man_field;
    logic              underflow, overflow;
    logic [W-1:0]      result;

    always_comb begin
        rnd       = {1'b0, s4_man[MAN_W+1:1]} + (MAN_W+2)'(s4_man[0]);
        rexp      = s4_exp + XEXP_W'(rnd[MAN_W+1]);
        man_field = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        underflow = s4_exp[XEXP_W-1] | (s4_exp == '0);
        overflow  = rexp > EXP_TOP;
        if (s4_zero || underflow) begin
            result = '0;
        end else if (overflow) begin
            result = {s4_sign, {(W-1){1'b1}}};
        end else begin
            result = {s4_sign, rexp[EXP_W-1:0], man_field};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            data_sum_o <= '0;
        end else if (en) begin
            valid_o    <= s4_valid;
            data_sum_o <= result;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe at EXP_W=5, MAN_W=6 with hand-computed vectors.
module tb_fp_add_pipe;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [11:0] data_1_i;
    logic [11:0] data_2_i;
    logic        sub_i;
    logic        valid_o;
    logic        ready_i;
    logic [11:0] data_sum_o;

    typedef struct {
        logic [11:0] data;
        int          issueCyc;
        bit          checkLat;
        int          tag;
    } expItem_t;

    expItem_t expQ[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [11:0] vecA [12];
    logic [11:0] vecB [12];
    logic        vecS [12];
    logic [11:0] vecE [12];
    int          streamIdx [8];

    fp_add_pipe dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_1_i   (data_1_i),
        .data_2_i   (data_2_i),
        .sub_i      (sub_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_sum_o (data_sum_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Drives one operand pair from just after a rising edge and holds it until accepted.
    task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b, input logic sub,
                                 input logic [11:0] expv, input bit checkLat, input int tag);
        expItem_t item;
        bit accepted = 1'b0;
        valid_i  = 1'b1;
        data_1_i = a;
        data_2_i = b;
        sub_i    = sub;
        for (int n = 0; n < 64 && !accepted; n++) begin
            @(negedge clk_i);
            if (ready_o) begin
                accepted      = 1'b1;
                item.data     = expv;
                item.issueCyc = cyc;
                item.checkLat = checkLat;
                item.tag      = tag;
                expQ.push_back(item);
            end
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        if (!accepted) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout_%0d: got no ready_o, expected acceptance", tag);
        end
    endtask

    task automatic waitDrain(input string name);
        for (int n = 0; n < 200 && expQ.size() != 0; n++) @(negedge clk_i);
        checkOutput(name, expQ.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every presented-and-accepted result is checked against the queue head.
    always @(negedge clk_i) begin
        expItem_t item;
        if (!rst_i && valid_o && ready_i) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", data_sum_o);
            end else begin
                item = expQ.pop_front();
                checkOutput($sformatf("result_%0d", item.tag), 32'(data_sum_o), 32'(item.data));
                if (item.checkLat)
                    checkOutput($sformatf("latency_%0d", item.tag), cyc - item.issueCyc, 5);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int validSeen;
        vecA[0]  = 12'h3C0; vecB[0]  = 12'h3C0; vecS[0]  = 1'b0; vecE[0]  = 12'h400;
        vecA[1]  = 12'h3C0; vecB[1]  = 12'h3C0; vecS[1]  = 1'b1; vecE[1]  = 12'h000;
        vecA[2]  = 12'h3E0; vecB[2]  = 12'hBC0; vecS[2]  = 1'b0; vecE[2]  = 12'h380;
        vecA[3]  = 12'h7FF; vecB[3]  = 12'h7FF; vecS[3]  = 1'b0; vecE[3]  = 12'h7FF;
        vecA[4]  = 12'h3C0; vecB[4]  = 12'h040; vecS[4]  = 1'b0; vecE[4]  = 12'h3C0;
        vecA[5]  = 12'h3C0; vecB[5]  = 12'h400; vecS[5]  = 1'b1; vecE[5]  = 12'hBC0;
        vecA[6]  = 12'h3C0; vecB[6]  = 12'h200; vecS[6]  = 1'b0; vecE[6]  = 12'h3C1;
        vecA[7]  = 12'h3C0; vecB[7]  = 12'h1C0; vecS[7]  = 1'b0; vecE[7]  = 12'h3C0;
        vecA[8]  = 12'h041; vecB[8]  = 12'h040; vecS[8]  = 1'b1; vecE[8]  = 12'h000;
        vecA[9]  = 12'h03F; vecB[9]  = 12'h3C0; vecS[9]  = 1'b0; vecE[9]  = 12'h3C0;
        vecA[10] = 12'hFFF; vecB[10] = 12'hFFF; vecS[10] = 1'b0; vecE[10] = 12'hFFF;
        vecA[11] = 12'h3E0; vecB[11] = 12'h380; vecS[11] = 1'b0; vecE[11] = 12'h400;
        streamIdx = '{0, 2, 3, 5, 6, 8, 10, 11};

        rst_i    = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        data_1_i = '0;
        data_2_i = '0;
        sub_i    = 1'b0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_valid_o", valid_o, 0);
        checkOutput("reset_data_sum_o", data_sum_o, 0);
        checkOutput("reset_ready_o", ready_o, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        $display("[TB] reset released, directed vectors follow");

        for (int i = 0; i < 12; i++)
            applyStimulus(vecA[i], vecB[i], vecS[i], vecE[i], i == 0, i + 1);
        waitDrain("drain_directed");

        $display("[TB] stream with downstream stall");
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus(vecA[streamIdx[i]], vecB[streamIdx[i]], vecS[streamIdx[i]],
                                  vecE[streamIdx[i]], 1'b0, 100 + i);
            end
            begin
                repeat (6) @(posedge clk_i);
                #1;
                ready_i = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_i);
                    checkOutput("stall_ready_o", ready_o, 0);
                    checkOutput("stall_valid_held", valid_o, 1);
                    if (expQ.size() > 0)
                        checkOutput("stall_data_held", 32'(data_sum_o), 32'(expQ[0].data));
                    else
                        checkOutput("stall_queue_depth", 0, 1);
                    @(posedge clk_i);
                end
                #1;
                ready_i = 1'b1;
            end
        join
        waitDrain("drain_stream");

        $display("[TB] reset during operation");
        applyStimulus(12'h3C0, 12'h3C0, 1'b0, 12'h400, 1'b0, 200);
        rst_i = 1'b1;
        expQ.delete();
        valid_i  = 1'b1;
        data_1_i = 12'h3E0;
        data_2_i = 12'h3E0;
        sub_i    = 1'b0;
        @(negedge clk_i);
        checkOutput("midreset_ready_o", ready_o, 1);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checkOutput("midreset_valid_o", valid_o, 0);
        checkOutput("midreset_data_sum_o", data_sum_o, 0);
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        validSeen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_i);
            if (valid_o) validSeen++;
        end
        checkOutput("flushed_results", validSeen, 0);
        @(posedge clk_i);
        #1;

        applyStimulus(vecA[11], vecB[11], vecS[11], vecE[11], 1'b1, 300);
        waitDrain("drain_post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
